// File: rtl/gray_uart_packer.sv
// Purpose: packs two 4-bit gray nibbles per byte, prefixes each frame with a 2-byte sync header, buffers in a FWFT byte FIFO.
// Latency: a byte pushed into an empty FIFO shows on tx_data/tx_valid the cycle after the push.
// Backpressure: tx_ready low fills the FIFO; when full, header/pad emission stalls and pix_ready drops in NIB1.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   frame_start         1-cycle pulse announcing a new frame
//   pix_valid/pix_ready pixel handshake; pix_data[7:4] carries the gray nibble
//   tx_data/tx_valid    FIFO head towards the UART; tx_ready pops it
//   fifo_level          bytes currently buffered (0..FIFO_DEPTH)
//   frame_drop          sticky flag: frame_start seen while a header was still pending
module gray_uart_packer #(
    parameter int         FIFO_DEPTH = 16,   // power of 2, >= 4
    parameter logic [7:0] HDR0       = 8'hA5,
    parameter logic [7:0] HDR1       = 8'h5A
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          pix_valid,
    input  logic [11:0]                   pix_data,
    output logic                          pix_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_NIB0,
        S_NIB1,
        S_PAD
    } state_t;

    state_t         state;
    logic           frame_req;
    logic [3:0]     hold;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    logic           full;
    logic           empty;
    logic           accept;
    logic           push;
    logic [7:0]     push_dat;
    logic           pop;

    // Only the G nibble carries the gray value; the other channels are duplicates.
    logic           unused_pix_bits;
    assign unused_pix_bits = ^{pix_data[11:8], pix_data[3:0]};

    assign full     = (fifo_level == FULL_LVL);
    assign empty    = (fifo_level == '0);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign accept   = pix_valid && pix_ready;

    always_comb begin
        pix_ready = 1'b0;
        case (state)
            S_IDLE:  pix_ready = 1'b1;
            S_NIB0:  pix_ready = !frame_req;
            S_NIB1:  pix_ready = !full && !frame_req;
            default: pix_ready = 1'b0;
        endcase
    end

    // Push decision uses the level at cycle start: a same-cycle pop never frees a slot.
    always_comb begin
        push     = 1'b0;
        push_dat = 8'h00;
        case (state)
            S_HDR0: begin
                push     = !full;
                push_dat = HDR0;
            end
            S_HDR1: begin
                push     = !full;
                push_dat = HDR1;
            end
            S_NIB1: begin
                push     = accept;
                push_dat = {hold, pix_data[7:4]};
            end
            S_PAD: begin
                push     = !full;
                push_dat = {hold, 4'h0};
            end
            default: begin
                push     = 1'b0;
                push_dat = 8'h00;
            end
        endcase
    end

    // Storage has no reset; tx_data is masked while empty so stale contents never leak.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            frame_req  <= 1'b0;
            frame_drop <= 1'b0;
            hold       <= 4'h0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase

            // A second request while one is pending is merged into it and flagged.
            if (frame_start && frame_req) begin
                frame_drop <= 1'b1;
            end
            if (state == S_HDR0 && push) begin
                frame_req <= 1'b0;
            end else if (frame_start) begin
                frame_req <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (frame_req) state <= S_HDR0;
                end
                S_HDR0: begin
                    if (!full) state <= S_HDR1;
                end
                S_HDR1: begin
                    if (!full) state <= S_NIB0;
                end
                S_NIB0: begin
                    if (frame_req) begin
                        state <= S_HDR0;
                    end else if (accept) begin
                        hold  <= pix_data[7:4];
                        state <= S_NIB1;
                    end
                end
                S_NIB1: begin
                    // An odd pixel left in hold is flushed as a padded byte before the next header.
                    if (frame_req) begin
                        state <= S_PAD;
                    end else if (accept) begin
                        state <= S_NIB0;
                    end
                end
                S_PAD: begin
                    if (!full) state <= S_HDR0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_uart_packer.sv
module tb_gray_uart_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pix_valid;
    logic [11:0] pix_data;
    logic        pix_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [4:0]  fifo_level;
    logic        frame_drop;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q [$];

    always #5 clk = ~clk;

    gray_uart_packer #(.FIFO_DEPTH(16), .HDR0(8'hA5), .HDR1(8'h5A)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .fifo_level  (fifo_level),
        .frame_drop  (frame_drop)
    );

    // Byte collector: anything shown with tx_valid && tx_ready at the negedge is popped at the next posedge.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) rx_q.push_back(tx_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] nib(int i);
        return 4'((i * 3) % 16);
    endfunction

    function automatic logic [11:0] pat(int i);
        logic [3:0] g;
        g = nib(i);
        return {g ^ 4'h5, g, ~g};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = 12'h000;
        tick();
        rst = 1'b0;
        rx_q.delete();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Frame pulse plus the three cycles needed to reach NIB0 when the FIFO has room.
    task automatic start_frame();
        pulse_frame();
        repeat (3) tick();
    endtask

    task automatic send_pix(input logic [11:0] d);
        bit ok;
        ok        = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        for (int i = 0; i < 100; i++) begin
            if (pix_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        pix_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_pix_timeout pixel=%h pix_ready=%b required=1", d, pix_ready);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 200; i++) begin
            if (fifo_level == 5'd0 && !tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain_timeout fifo_level=%0d required=0", fifo_level);
        end
    endtask

    task automatic test_reset_and_basic();
        logic [7:0] expq [$];
        logic [7:0] got;
        tx_ready = 1'b1;
        do_reset();
        total++; if (tx_valid !== 1'b0)    begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        total++; if (tx_data !== 8'h00)    begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        total++; if (fifo_level !== 5'd0)  begin bad++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
        total++; if (frame_drop !== 1'b0)  begin bad++; $display("FAIL rst_frame_drop got=%b exp=0", frame_drop); end
        total++; if (pix_ready !== 1'b1)   begin bad++; $display("FAIL rst_pix_ready got=%b exp=1", pix_ready); end

        pulse_frame();
        tick();
        total++; if (tx_valid !== 1'b0)    begin bad++; $display("FAIL t1_pre_hdr_valid got=%b exp=0", tx_valid); end
        tick();
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5)
            begin bad++; $display("FAIL t1_hdr0_latency got=%b/%h exp=1/a5", tx_valid, tx_data); end
        tick();
        send_pix(12'h333);
        send_pix(12'h999);
        drain();
        expq = '{8'hA5, 8'h5A, 8'h39};
        total++; if (rx_q.size() !== expq.size())
            begin bad++; $display("FAIL t1_count got=%0d exp=%0d", rx_q.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            total++; if (got !== expq[k]) begin bad++; $display("FAIL t1_byte%0d got=%h exp=%h", k, got, expq[k]); end
        end
        total++; if (fifo_level !== 5'd0)  begin bad++; $display("FAIL t1_final_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_idle_discard();
        tx_ready = 1'b1;
        do_reset();
        pix_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix_data = {3{4'(i + 4)}};
            total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL t2_pix_ready%0d got=%b exp=1", i, pix_ready); end
            tick();
            total++; if (tx_valid !== 1'b0 || fifo_level !== 5'd0)
                begin bad++; $display("FAIL t2_idle%0d got valid=%b level=%0d exp 0/0", i, tx_valid, fifo_level); end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] expq [$];
        logic [7:0] got;
        logic [4:0] max_lvl;
        bit         rdy;
        int         idx;
        tx_ready = 1'b0;
        do_reset();
        start_frame();
        total++; if (fifo_level !== 5'd2) begin bad++; $display("FAIL t3_hdr_level got=%0d exp=2", fifo_level); end
        idx = 0;
        max_lvl = '0;
        pix_valid = 1'b1;
        for (int c = 0; c < 300 && idx < 29; c++) begin
            pix_data = pat(idx);
            rdy = pix_ready;
            tick();
            if (rdy) idx++;
            if (fifo_level > max_lvl) max_lvl = fifo_level;
        end
        total++; if (idx !== 29) begin bad++; $display("FAIL t3_fill_count got=%0d exp=29", idx); end
        pix_data = pat(29);
        for (int c = 0; c < 4; c++) begin
            total++; if (pix_ready !== 1'b0 || fifo_level !== 5'd16)
                begin bad++; $display("FAIL t3_full%0d got ready=%b level=%0d exp 0/16", c, pix_ready, fifo_level); end
            tick();
        end
        total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL t3_head got=%h exp=a5", tx_data); end
        tx_ready = 1'b1;
        for (int c = 0; c < 300 && idx < 40; c++) begin
            pix_data = pat(idx);
            rdy = pix_ready;
            tick();
            if (rdy) idx++;
            if (fifo_level > max_lvl) max_lvl = fifo_level;
        end
        pix_valid = 1'b0;
        drain();
        total++; if (max_lvl !== 5'd16) begin bad++; $display("FAIL t3_max_level got=%0d exp=16", max_lvl); end
        expq = '{8'hA5, 8'h5A};
        for (int j = 0; j < 20; j++) expq.push_back({nib(2 * j), nib(2 * j + 1)});
        total++; if (rx_q.size() !== 22) begin bad++; $display("FAIL t3_count got=%0d exp=22", rx_q.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            total++; if (got !== expq[k]) begin bad++; $display("FAIL t3_byte%0d got=%h exp=%h", k, got, expq[k]); end
        end
    endtask

    task automatic test_odd_pad();
        logic [7:0] expq [$];
        logic [7:0] got;
        tx_ready = 1'b1;
        do_reset();
        start_frame();
        send_pix(12'h777);
        pulse_frame();
        repeat (8) tick();
        drain();
        expq = '{8'hA5, 8'h5A, 8'h70, 8'hA5, 8'h5A};
        total++; if (rx_q.size() !== expq.size())
            begin bad++; $display("FAIL t4_count got=%0d exp=%0d", rx_q.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            total++; if (got !== expq[k]) begin bad++; $display("FAIL t4_byte%0d got=%h exp=%h", k, got, expq[k]); end
        end
        total++; if (frame_drop !== 1'b0) begin bad++; $display("FAIL t4_no_drop got=%b exp=0", frame_drop); end
    endtask

    task automatic test_frame_drop();
        logic [7:0] expq [$];
        logic [7:0] got;
        tx_ready = 1'b0;
        do_reset();
        start_frame();
        for (int i = 0; i < 28; i++) send_pix(pat(i));
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL t5_full_level got=%0d exp=16", fifo_level); end
        pulse_frame();
        total++; if (frame_drop !== 1'b0) begin bad++; $display("FAIL t5_first_req got=%b exp=0", frame_drop); end
        tick();
        pulse_frame();
        total++; if (frame_drop !== 1'b1) begin bad++; $display("FAIL t5_drop_set got=%b exp=1", frame_drop); end
        pulse_frame();
        tick();
        total++; if (frame_drop !== 1'b1 || fifo_level !== 5'd16)
            begin bad++; $display("FAIL t5_stall got drop=%b level=%0d exp 1/16", frame_drop, fifo_level); end
        tx_ready = 1'b1;
        drain();
        expq = '{8'hA5, 8'h5A};
        for (int j = 0; j < 14; j++) expq.push_back({nib(2 * j), nib(2 * j + 1)});
        expq.push_back(8'hA5);
        expq.push_back(8'h5A);
        total++; if (rx_q.size() !== expq.size())
            begin bad++; $display("FAIL t5_count got=%0d exp=%0d", rx_q.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            total++; if (got !== expq[k]) begin bad++; $display("FAIL t5_byte%0d got=%h exp=%h", k, got, expq[k]); end
        end
        total++; if (frame_drop !== 1'b1) begin bad++; $display("FAIL t5_drop_sticky got=%b exp=1", frame_drop); end
        do_reset();
        total++; if (frame_drop !== 1'b0) begin bad++; $display("FAIL t5_drop_cleared got=%b exp=0", frame_drop); end
    endtask

    task automatic test_mid_frame_reset();
        logic [7:0] expq [$];
        logic [7:0] got;
        tx_ready = 1'b0;
        do_reset();
        start_frame();
        for (int i = 0; i < 7; i++) send_pix(pat(i));
        total++; if (fifo_level !== 5'd5) begin bad++; $display("FAIL t6_pre_level got=%0d exp=5", fifo_level); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rx_q.delete();
        total++; if (tx_valid !== 1'b0)   begin bad++; $display("FAIL t6_tx_valid got=%b exp=0", tx_valid); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL t6_level got=%0d exp=0", fifo_level); end
        total++; if (pix_ready !== 1'b1)  begin bad++; $display("FAIL t6_pix_ready got=%b exp=1", pix_ready); end
        total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL t6_tx_data got=%h exp=00", tx_data); end
        tx_ready  = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 12'hEEE;
        repeat (3) tick();
        pix_valid = 1'b0;
        tick();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL t6_idle_discard got=%b exp=0", tx_valid); end
        start_frame();
        send_pix(12'h0C0);
        send_pix(12'h0D0);
        drain();
        expq = '{8'hA5, 8'h5A, 8'hCD};
        total++; if (rx_q.size() !== expq.size())
            begin bad++; $display("FAIL t6_count got=%0d exp=%0d", rx_q.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
            total++; if (got !== expq[k]) begin bad++; $display("FAIL t6_byte%0d got=%h exp=%h", k, got, expq[k]); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = 12'h000;
        tx_ready    = 1'b0;
        test_reset_and_basic();
        test_idle_discard();
        test_backpressure();
        test_odd_pad();
        test_frame_drop();
        test_mid_frame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
